// File: rtl/mycpu_pkg.sv
// Shared datapath types: function-select encoding, multi-cycle FU state, flag bundle.
package mycpu_pkg;

  typedef enum logic [3:0] {
    FS_MOVA = 4'd0,
    FS_INC  = 4'd1,
    FS_ADD  = 4'd2,
    FS_MUL  = 4'd3,
    FS_SRA  = 4'd4,
    FS_SUB  = 4'd5,
    FS_DEC  = 4'd6,
    FS_SLA  = 4'd7,
    FS_AND  = 4'd8,
    FS_OR   = 4'd9,
    FS_XOR  = 4'd10,
    FS_NOT  = 4'd11,
    FS_MOVB = 4'd12,
    FS_SHR  = 4'd13,
    FS_SHL  = 4'd14,
    FS_CLR  = 4'd15
  } fs_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } fu_state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } fu_flags_t;

endpackage

// File: rtl/fu_mc_mul_iter.sv
// Radix-2 shift-add multiplier, one partial-product step per cycle.
// p is the accumulator after the current step; it holds the full product
// in the cycle where done is high, so the caller registers it on that edge.
module fu_mul_iter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] p
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic              busy_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] mcand_r;
  logic [DATA_W-1:0] mplier_r;
  logic [DATA_W-1:0] step_s;

  // One partial-product accumulation for the current multiplier bit.
  always_comb begin
    step_s = acc_r;
    if (mplier_r[0]) begin
      step_s = acc_r + mcand_r;
    end else begin
      step_s = acc_r;
    end
  end

  assign busy = busy_r;
  assign done = busy_r && (cnt_r == LAST);
  assign p    = step_s;

  // Operand capture on start, then shift multiplicand left / multiplier right each step.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r   <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {DATA_W{1'b0}};
      mcand_r  <= {DATA_W{1'b0}};
      mplier_r <= {DATA_W{1'b0}};
    end else if (start) begin
      busy_r   <= 1'b1;
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {DATA_W{1'b0}};
      mcand_r  <= a;
      mplier_r <= b;
    end else if (busy_r) begin
      acc_r    <= step_s;
      mcand_r  <= {mcand_r[DATA_W-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[DATA_W-1:1]};
      cnt_r    <= cnt_r + CNT_W'(1);
      busy_r   <= (cnt_r != LAST);
    end else begin
      busy_r   <= busy_r;
    end
  end

endmodule

// File: rtl/fu_mc.sv
// Multi-cycle function unit: registered results, valid/ready on both sides,
// iterative multiply, full Z/N/C/V flags. Single op in flight.
module fu_mc
  import mycpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [3:0]        fs_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] f_out,
  output logic              z_out,
  output logic              n_out,
  output logic              c_out,
  output logic              v_out
);

  localparam int MSB = DATA_W - 1;

  fu_state_t         state_r, state_nxt_s;
  fs_t               fs_s;
  logic              ready_s, accept_s, start_s;
  logic [DATA_W:0]   wide_s;
  logic [DATA_W-1:0] alu_f_s;
  logic              alu_c_s, alu_v_s;
  logic              mul_busy_s, mul_done_s;
  logic [DATA_W-1:0] mul_p_s;
  logic [DATA_W-1:0] f_r;
  fu_flags_t         flags_r;

  function automatic fu_flags_t make_flags(input logic [DATA_W-1:0] f,
                                           input logic c, input logic v);
    fu_flags_t fl;
    fl.z = (f == {DATA_W{1'b0}});
    fl.n = f[MSB];
    fl.c = c;
    fl.v = v;
    return fl;
  endfunction

  assign fs_s      = fs_t'(fs_in);
  assign ready_s   = (state_r == IDLE) || ((state_r == DONE) && ready_in);
  assign accept_s  = valid_in && ready_s;
  assign start_s   = accept_s && (fs_s == FS_MUL);

  fu_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(start_s),
    .a    (a_in),
    .b    (b_in),
    .busy (mul_busy_s),
    .done (mul_done_s),
    .p    (mul_p_s)
  );

  // Single-cycle result and carry/overflow for every non-multiply op.
  always_comb begin
    wide_s  = {(DATA_W+1){1'b0}};
    alu_f_s = {DATA_W{1'b0}};
    alu_c_s = 1'b0;
    alu_v_s = 1'b0;
    case (fs_s)
      FS_MOVA: alu_f_s = a_in;
      FS_INC: begin
        wide_s  = {1'b0, a_in} + {{DATA_W{1'b0}}, 1'b1};
        alu_f_s = wide_s[MSB:0];
        alu_c_s = wide_s[DATA_W];
        alu_v_s = (a_in == {1'b0, {(DATA_W-1){1'b1}}});
      end
      FS_ADD: begin
        wide_s  = {1'b0, a_in} + {1'b0, b_in};
        alu_f_s = wide_s[MSB:0];
        alu_c_s = wide_s[DATA_W];
        alu_v_s = (a_in[MSB] == b_in[MSB]) && (wide_s[MSB] != a_in[MSB]);
      end
      FS_MUL:  alu_f_s = {DATA_W{1'b0}};
      FS_SRA: begin
        alu_f_s = {b_in[MSB], b_in[MSB:1]};
        alu_c_s = b_in[0];
      end
      FS_SUB: begin
        wide_s  = {1'b0, a_in} - {1'b0, b_in};
        alu_f_s = wide_s[MSB:0];
        alu_c_s = wide_s[DATA_W];
        alu_v_s = (a_in[MSB] != b_in[MSB]) && (wide_s[MSB] != a_in[MSB]);
      end
      FS_DEC: begin
        wide_s  = {1'b0, a_in} - {{DATA_W{1'b0}}, 1'b1};
        alu_f_s = wide_s[MSB:0];
        alu_c_s = (a_in == {DATA_W{1'b0}});
        alu_v_s = (a_in == {1'b1, {(DATA_W-1){1'b0}}});
      end
      FS_SLA: begin
        alu_f_s = {b_in[MSB-1:0], 1'b0};
        alu_c_s = b_in[MSB];
        alu_v_s = b_in[MSB] ^ b_in[MSB-1];
      end
      FS_AND:  alu_f_s = a_in & b_in;
      FS_OR:   alu_f_s = a_in | b_in;
      FS_XOR:  alu_f_s = a_in ^ b_in;
      FS_NOT:  alu_f_s = ~a_in;
      FS_MOVB: alu_f_s = b_in;
      FS_SHR: begin
        alu_f_s = {1'b0, b_in[MSB:1]};
        alu_c_s = b_in[0];
      end
      FS_SHL: begin
        alu_f_s = {b_in[MSB-1:0], 1'b0};
        alu_c_s = b_in[MSB];
      end
      FS_CLR:  alu_f_s = {DATA_W{1'b0}};
      default: alu_f_s = {DATA_W{1'b0}};
    endcase
  end

  // Next-state: accept decides MUL vs DONE; DONE holds under back-pressure.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = start_s ? MUL : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          state_nxt_s = DONE;
        end else if (mul_busy_s) begin
          state_nxt_s = MUL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_nxt_s = start_s ? MUL : DONE;
        end else if (ready_in) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Result/flag registers: load on non-MUL accept or on the last multiply step, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_r     <= {DATA_W{1'b0}};
      flags_r <= fu_flags_t'(4'b0000);
    end else if (accept_s && !start_s) begin
      f_r     <= alu_f_s;
      flags_r <= make_flags(alu_f_s, alu_c_s, alu_v_s);
    end else if ((state_r == MUL) && mul_done_s) begin
      f_r     <= mul_p_s;
      flags_r <= make_flags(mul_p_s, 1'b0, 1'b0);
    end else begin
      f_r     <= f_r;
      flags_r <= flags_r;
    end
  end

  assign ready_out = ready_s;
  assign valid_out = (state_r == DONE);
  assign f_out     = f_r;
  assign z_out     = flags_r.z;
  assign n_out     = flags_r.n;
  assign c_out     = flags_r.c;
  assign v_out     = flags_r.v;

endmodule

// File: tb/tb_fu_mc.sv
// Scoreboard bench for fu_mc (DATA_W = 16): directed scenarios then random traffic.
module tb_fu_mc;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b1;
  logic [15:0] a_in = 16'h0000;
  logic [15:0] b_in = 16'h0000;
  logic [3:0]  fs_in = 4'd0;
  logic        ready_out, valid_out, z_out, n_out, c_out, v_out;
  logic [15:0] f_out;

  fu_mc #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .a_in(a_in), .b_in(b_in), .fs_in(fs_in), .valid_out(valid_out),
    .ready_in(ready_in), .f_out(f_out), .z_out(z_out), .n_out(n_out),
    .c_out(c_out), .v_out(v_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] f;
    logic        z, n, c, v;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   nchk = 0;
  int   npass = 0;
  bit   armed = 1'b0;
  bit   prev_rst = 1'b0;

  // Reference: arithmetic on integers, result reduced modulo 2^16.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input fs_t fs);
    exp_t   e;
    longint ua, ub, sa, sb, r, s;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    r = 0; e.c = 1'b0; e.v = 1'b0;
    case (fs)
      FS_MOVA: r = ua;
      FS_INC:  begin r = ua + 1; e.c = (ua == 65535); e.v = (sa + 1 > 32767); end
      FS_ADD:  begin r = ua + ub; e.c = (r > 65535); s = sa + sb; e.v = (s > 32767) || (s < -32768); end
      FS_MUL:  r = ua * ub;
      FS_SRA:  begin r = (sb >= 0) ? sb / 2 : (sb - 1) / 2; e.c = (ub % 2 == 1); end
      FS_SUB:  begin r = ua - ub; e.c = (ua < ub); s = sa - sb; e.v = (s > 32767) || (s < -32768); end
      FS_DEC:  begin r = ua - 1; e.c = (ua == 0); e.v = (sa - 1 < -32768); end
      FS_SLA:  begin r = ub * 2; e.c = (ub >= 32768); e.v = (sb * 2 > 32767) || (sb * 2 < -32768); end
      FS_AND:  r = ua & ub;
      FS_OR:   r = ua | ub;
      FS_XOR:  r = ua ^ ub;
      FS_NOT:  r = 65535 - ua;
      FS_MOVB: r = ub;
      FS_SHR:  begin r = ub / 2; e.c = (ub % 2 == 1); end
      FS_SHL:  begin r = ub * 2; e.c = (ub >= 32768); end
      default: r = 0;
    endcase
    e.f   = 16'(r & 64'hFFFF);
    e.z   = (e.f == 16'h0000);
    e.n   = (e.f >= 16'h8000);
    e.acc = 0;
    e.lat = (fs == FS_MUL) ? 17 : 1;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
  endtask

  // Cycle counter used to time result latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: expected valid/ready from the scoreboard, data compared while presented.
  always @(negedge clk) begin
    bit   exp_v, exp_r;
    exp_t e;
    exp_v = (sbq.size() > 0) && (cyc >= sbq[0].acc + sbq[0].lat);
    exp_r = (sbq.size() == 0) || (exp_v && ready_in);
    if (armed) begin
      chk("valid_out", {31'd0, valid_out}, {31'd0, exp_v});
      chk("ready_out", {31'd0, ready_out}, {31'd0, exp_r});
      if (prev_rst)
        chk("reset_outputs", {12'd0, f_out, z_out, n_out, c_out, v_out}, 32'd0);
      if (exp_v) begin
        chk("result", {12'd0, f_out, z_out, n_out, c_out, v_out},
            {12'd0, sbq[0].f, sbq[0].z, sbq[0].n, sbq[0].c, sbq[0].v});
        if (ready_in) void'(sbq.pop_front());
      end
    end
    if (rst) begin
      sbq.delete();
      armed    = 1'b1;
      prev_rst = 1'b1;
    end else begin
      prev_rst = 1'b0;
      if (armed && valid_in && exp_r) begin
        e = model(a_in, b_in, fs_t'(fs_in));
        e.acc = cyc;
        sbq.push_back(e);
      end
    end
  end

  // Drive one cycle of inputs just after the active edge.
  task automatic step(input logic v, input fs_t fs, input logic [15:0] a,
                      input logic [15:0] b, input logic rdy);
    valid_in = v; fs_in = fs; a_in = a; b_in = b; ready_in = rdy;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, FS_MOVA, 16'h0000, 16'h0000, 1'b1);
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(5, 0))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    logic [3:0] rfs;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    // ADD overflow into sign bit
    step(1'b1, FS_ADD, 16'h7FFF, 16'h0001, 1'b1);
    idle(2);
    // SUB borrow then SRA back-to-back
    step(1'b1, FS_SUB, 16'h0003, 16'h0005, 1'b1);
    step(1'b1, FS_SRA, 16'h0000, 16'h8001, 1'b1);
    idle(2);
    // Multi-cycle multiply
    step(1'b1, FS_MUL, 16'hFFFD, 16'h0007, 1'b1);
    idle(20);
    // Back-pressure: result held 5 cycles while a new op waits
    step(1'b1, FS_ADD, 16'h1234, 16'h4321, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, FS_XOR, 16'hF0F0, 16'h0FF0, 1'b0);
    step(1'b1, FS_XOR, 16'hF0F0, 16'h0FF0, 1'b1);
    idle(2);
    // Reset in the middle of a multiply
    step(1'b1, FS_MUL, 16'h1234, 16'h5678, 1'b1);
    idle(7);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(20);
    // Boundaries
    step(1'b1, FS_INC, 16'hFFFF, 16'h0000, 1'b1);
    step(1'b1, FS_DEC, 16'h8000, 16'h0000, 1'b1);
    step(1'b1, FS_CLR, 16'h5555, 16'hAAAA, 1'b1);
    step(1'b1, FS_SLA, 16'h0000, 16'h4000, 1'b1);
    step(1'b1, FS_SHR, 16'h0000, 16'h0003, 1'b1);
    idle(2);
    // Random traffic with back-pressure and occasional reset
    for (int i = 0; i < 2500; i++) begin
      rfs = 4'($urandom_range(15, 0));
      rst = ($urandom_range(199, 0) == 0);
      step($urandom_range(9, 0) < 7, fs_t'(rfs), pick_operand(), pick_operand(),
           $urandom_range(3, 0) != 0);
    end
    rst = 1'b0;
    idle(25);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/fu_mc.md
# fu_mc

Multi-cycle, width-parametrised function unit for the datapath. It executes the same 16 `fs_t` operations as the single-cycle FU. It adds registered results, a valid/ready handshake on both sides, an iterative shift-add multiplier, and full Z/N/C/V flags. It sits between the register-file read ports and the write-back mux, and the control unit stalls on `ready_out`/`valid_out`.

## Interface
Parameters:
- `DATA_W`, default 16: operand and result width. Must be at least 4.

Ports:
- `clk`, in, 1: clock. Everything is rising-edge.
- `rst`, in, 1: reset. **Synchronous, active-high.**
- `valid_in`, in, 1: an operation is offered on `a_in`, `b_in`, `fs_in`.
- `ready_out`, out, 1: the unit can accept an operation this cycle.
- `a_in`, in, `DATA_W`: operand A.
- `b_in`, in, `DATA_W`: operand B.
- `fs_in`, in, 4: function select, cast to `fs_t`.
- `valid_out`, out, 1: `f_out` and the flags hold a finished result.
- `ready_in`, in, 1: the consumer takes the result this cycle.
- `f_out`, out, `DATA_W`: result.
- `z_out`, out, 1: result is zero.
- `n_out`, out, 1: result sign, which is `f_out[DATA_W-1]`.
- `c_out`, out, 1: carry, borrow, or shifted-out bit.
- `v_out`, out, 1: signed overflow.

## Operation
- **Accept:** an operation is accepted when `valid_in && ready_out`.
  - `a_in`, `b_in` and `fs_in` are captured into internal registers.
  - Inputs are ignored in all other cycles.
- **FSM states:** IDLE, MUL, DONE.
  - IDLE to DONE: accept of a non-MUL op. The result is computed and registered on the accept edge.
  - IDLE to MUL: accept of FMUL.
  - MUL to DONE: after exactly `DATA_W` iterations.
  - DONE, with `ready_in` high and no new accept: go to IDLE.
  - DONE, with `ready_in` high and a new accept: back-to-back, same rules as from IDLE.
  - DONE, with `ready_in` low: hold.
- **Handshake signals:**
  - `ready_out = (state==IDLE) || (state==DONE && ready_in)`.
  - `valid_out = (state==DONE)`.
- **Opcode semantics** (encoding as in `fs_t`; all arithmetic is modulo 2^`DATA_W`):
  - MOVA: `f = a`.
  - INC: `f = a+1`. `c` is the carry out (a all ones). `v = (a == 0111..1)`.
  - ADD: `f = a+b`. `c` is the carry out. `v` is set when the operands have the same sign and the result sign differs.
  - MUL: `f` is the low `DATA_W` bits of `a*b`. These bits are identical for signed and unsigned operands. `c = v = 0`.
  - SRA: `f = b >>> 1`. `c = b[0]`.
  - SUB: `f = a-b`. `c` is the unsigned borrow (`a<b`). `v` is set when the operands have different signs and the result sign differs from `a`.
  - DEC: `f = a-1`. `c = (a == 0)`. `v = (a == 100..0)`.
  - SLA: `f = b << 1`. `c = b[MSB]`. `v = b[MSB] ^ b[MSB-1]`.
  - AND, OR, XOR: `f = a op b`.
  - NOT: `f = ~a`.
  - MOVB: `f = b`.
  - SHR: `f = b >> 1`. `c = b[0]`.
  - SHL: `f = b << 1`. `c = b[MSB]`.
  - CLR: `f = 0`.
  - `c` and `v` are 0 for every op not listed with them.
- **Z and N:** derived from the final `f` for every op, CLR included (which gives z=1, n=0).
- **MUL iteration:** radix-2 shift-add on the captured operands. There is one partial-product step per cycle, and the accumulator is `DATA_W` bits.
- **Outputs held:** `f_out` and the flags are registers. They stay stable while `valid_out && !ready_in`, and they keep their last value in IDLE.

## Timing
- **Reset (`rst` high at an edge):**
  - State goes to IDLE and any in-flight op is aborted.
  - `valid_out` = 0, `f_out` = 0, and `z_out`, `n_out`, `c_out`, `v_out` = 0.
  - `ready_out` = 1 in the first cycle after reset deasserts.
- **Latency:** measured from the accept edge T to the first cycle with `valid_out` = 1.
  - Non-MUL: the cycle after T (1 cycle).
  - MUL: `DATA_W`+1 cycles (17 for `DATA_W` = 16).
- **Throughput:** one non-MUL op per cycle while `ready_in` stays high.
- **Single op in flight:** nothing is accepted while in MUL.
- **Reset mid-MUL or in DONE:** the result is discarded and no `valid_out` pulse follows.

## Structure
- `mycpu_pkg` holds:
  - `fs_t`, the existing 4-bit encoding, unchanged.
  - A new `fu_state_t` enum (IDLE, MUL, DONE).
  - A new `fu_flags_t` packed struct {z, n, c, v}.
- Sub-module `fu_mul_iter`:
  - Ports: `clk`, `rst`, `start`, `a`, `b`, `busy`, `done`, `p`.
  - Holds the iteration counter, of width `$clog2(DATA_W+1)`.
  - The top-level FSM and the single-cycle op logic stay in `fu_mc`.

## Test plan
All scenarios use `DATA_W` = 16.
- **ADD:** ADD a=0x7FFF, b=0x0001, `ready_in`=1 -> f=0x8000, z=0, n=1, c=0, v=1, `valid_out` in the cycle after accept.
- **SUB:** SUB a=0x0003, b=0x0005 -> f=0xFFFE, n=1, c=1, v=0. Then SRA b=0x8001 back-to-back -> f=0xC000, n=1, c=1, with `ready_out` high throughout.
- **MUL:** MUL a=0xFFFD, b=0x0007 -> f=0xFFEB, n=1, `valid_out` exactly 17 cycles after accept, and `ready_out` low for cycles 1..16.
- **Back-pressure:** ADD result with `ready_in` held low for 5 cycles -> `f_out` and flags stable, `valid_out`=1, `ready_out`=0, and a new `valid_in` is ignored. On `ready_in`=1 the queued op is accepted that same cycle.
- **Reset mid-MUL:** `rst` asserted 8 cycles into MUL -> `valid_out`=0 and all outputs 0 the next cycle, `ready_out`=1, and no late result appears.
- **Boundaries:** INC a=0xFFFF -> f=0, z=1, c=1. DEC a=0x8000 -> f=0x7FFF, v=1. CLR -> z=1.
